// File: rtl/ppb_pkg.sv
// ppb_pkg: shared constants and bank-select encoding for ping_pong_buffer.
//   DATA_W  byte width of stored data
//   ADDR_W  conv read address width
//   DEPTH   entries per bank (one full tile)
//   PTR_W   write pointer width; holds 0..DEPTH inclusive so "full" is representable
package ppb_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 768;
  localparam int PTR_W  = $clog2(DEPTH + 1);

  typedef enum logic {
    PING = 1'b0,
    PONG = 1'b1
  } bank_sel_e;
endpackage

// File: rtl/ppb_bank_ram.sv
// ppb_bank_ram: simple dual-port RAM, one write port and one registered read port.
// Contents are never reset, so the array maps onto block RAM.
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read strobe; the read register holds while low
//   i_rd_addr  read address (caller keeps it below DEPTH)
//   o_rd_data  read data, one cycle after the address
module ppb_bank_ram #(
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int DEPTH = 768
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/ping_pong_buffer.sv
// ping_pong_buffer: double-buffered byte store. One bank fills from the stream
// while the conv engine randomly reads the other; i_switch_pingpong swaps roles.
// Optional build macro: PPB_OUTREG_EN adds a second output register (latency 2).
//   i_clk              clock, rising edge
//   i_rst_n            synchronous reset, active-low (overrides en)
//   en                 global enable; 0 freezes all state and outputs
//   i_switch_pingpong  0 = write PING / read PONG, 1 = write PONG / read PING
//   i_data_din         stream write data
//   i_data_din_vld     write strobe
//   i_conv_addr        conv read address into the read bank
//   o_conv_dout        read data (0 for addresses >= DEPTH)
//   o_pl_buffer_ready  write bank holds a complete tile
module ping_pong_buffer
  import ppb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              en,
  input  logic              i_switch_pingpong,
  input  logic [DATA_W-1:0] i_data_din,
  input  logic              i_data_din_vld,
  input  logic [ADDR_W-1:0] i_conv_addr,
  output logic [DATA_W-1:0] o_conv_dout,
  output logic              o_pl_buffer_ready
);
  localparam logic [PTR_W-1:0]  DEPTH_PTR  = PTR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic             r_sw_q;
  logic             r_ready;
  bank_sel_e        r_rd_sel;
  logic             r_rd_zero;

  logic              w_sw_chg;
  logic [PTR_W-1:0]  w_ptr_base;
  logic [PTR_W-1:0]  w_ptr_next;
  logic              w_wr_en;
  logic              w_ready_next;
  logic              w_rd_oor;
  logic [ADDR_W-1:0] w_rd_addr;
  bank_sel_e         w_wr_bank;
  bank_sel_e         w_rd_bank;
  logic [DATA_W-1:0] w_ram_dout [2];
  logic [DATA_W-1:0] w_dout1;

  // Bank roles follow the live switch input, not the registered copy.
  assign w_wr_bank = bank_sel_e'(i_switch_pingpong);
  assign w_rd_bank = bank_sel_e'(~i_switch_pingpong);
  assign w_sw_chg  = (i_switch_pingpong != r_sw_q);

  // Out-of-range reads are steered to address 0 and masked to zero at the output.
  assign w_rd_oor  = (i_conv_addr >= DEPTH_ADDR);
  assign w_rd_addr = w_rd_oor ? '0 : i_conv_addr;

  always_comb begin
    w_ptr_base   = r_wr_ptr;
    w_wr_en      = 1'b0;
    w_ptr_next   = r_wr_ptr;
    w_ready_next = r_ready;
    // A swap restarts the fill so a same-cycle write lands at address 0.
    if (w_sw_chg) begin
      w_ptr_base = '0;
    end
    w_wr_en    = en && i_data_din_vld && (w_ptr_base < DEPTH_PTR);
    w_ptr_next = w_wr_en ? (w_ptr_base + 1'b1) : w_ptr_base;
    // The pointer saturates at DEPTH, so "full" is exactly ready.
    w_ready_next = (w_ptr_next == DEPTH_PTR);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_sw_q    <= 1'b0;
      r_ready   <= 1'b0;
      r_rd_sel  <= PING;
      r_rd_zero <= 1'b1;
    end else if (en) begin
      r_wr_ptr  <= w_ptr_next;
      r_sw_q    <= i_switch_pingpong;
      r_ready   <= w_ready_next;
      r_rd_sel  <= w_rd_bank;
      r_rd_zero <= w_rd_oor;
    end
  end

  // Both banks read every enabled cycle; the registered select picks the one
  // that was the read bank when the address was presented.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      localparam bank_sel_e BANK = (gi == 0) ? PING : PONG;
      ppb_bank_ram #(
        .DW    (DATA_W),
        .AW    (ADDR_W),
        .DEPTH (DEPTH)
      ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en && (w_wr_bank == BANK)),
        .i_wr_addr (w_ptr_base[ADDR_W-1:0]),
        .i_wr_data (i_data_din),
        .i_rd_en   (en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_dout[gi])
      );
    end
  endgenerate

  // The RAM read register has no reset; r_rd_zero forces the reset value and
  // the out-of-range result without adding latency.
  assign w_dout1 = r_rd_zero ? '0 :
                   ((r_rd_sel == PONG) ? w_ram_dout[1] : w_ram_dout[0]);

`ifdef PPB_OUTREG_EN
  logic [DATA_W-1:0] r_dout2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dout2 <= '0;
    end else if (en) begin
      r_dout2 <= w_dout1;
    end
  end

  assign o_conv_dout = r_dout2;
`else
  assign o_conv_dout = w_dout1;
`endif

  assign o_pl_buffer_ready = r_ready;
endmodule

// File: tb/tb_ping_pong_buffer.sv
// tb_ping_pong_buffer: scoreboard bench for ping_pong_buffer. A driver issues
// one input set per cycle and pushes the expected outputs from a tile-level
// model; a monitor pops and compares after every rising edge.
module tb_ping_pong_buffer;
  import ppb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              sw;
  logic [DATA_W-1:0] din;
  logic              vld;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic              ready;

  always #5 clk = ~clk;

  ping_pong_buffer dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .en                (en),
    .i_switch_pingpong (sw),
    .i_data_din        (din),
    .i_data_din_vld    (vld),
    .i_conv_addr       (addr),
    .o_conv_dout       (dout),
    .o_pl_buffer_ready (ready)
  );

`ifdef PPB_OUTREG_EN
  localparam bit OUTREG = 1'b1;
`else
  localparam bit OUTREG = 1'b0;
`endif

  typedef struct {
    int dout;   // -1 = RAM byte never written, not checkable
    bit ready;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: two byte arrays, a count of bytes taken since the last
  // swap/reset, the last switch value seen while enabled, and the read pipe.
  int m_bank [2][DEPTH];
  int m_cnt;
  bit m_sw;
  int m_d1;
  int m_d2;

  task automatic step(input bit r, input bit e, input bit s, input bit v,
                      input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
    exp_t x;
    int   rd;
    rst_n = r; en = e; sw = s; vld = v; din = d; addr = a;
    if (!r) begin
      m_cnt = 0; m_sw = 1'b0; m_d1 = 0; m_d2 = 0;
    end else if (e) begin
      if (s != m_sw) m_cnt = 0;
      m_sw = s;
      // Read bank is the one not being written: switch=1 reads PING (0).
      rd = (int'(a) < DEPTH) ? m_bank[s ? 0 : 1][int'(a)] : 0;
      if (v && m_cnt < DEPTH) begin
        m_bank[s ? 1 : 0][m_cnt] = int'(d);
        m_cnt++;
      end
      m_d2 = m_d1;
      m_d1 = rd;
    end
    x.dout  = OUTREG ? m_d2 : m_d1;
    x.ready = (m_cnt == DEPTH);
    q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one expectation per rising edge.
  initial begin : monitor
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        checks++;
        if (ready !== e.ready) begin
          errors++;
          $display("FAIL ready cyc=%0d got=%0b exp=%0b", cyc, ready, e.ready);
        end
        if (e.dout >= 0) begin
          checks++;
          if (dout !== e.dout[DATA_W-1:0]) begin
            errors++;
            $display("FAIL dout cyc=%0d got=%0d exp=%0d", cyc, dout, e.dout);
          end
        end
      end
    end
  end

  task automatic note(input string name);
    $display("phase %s done: checks=%0d errors=%0d", name, checks, errors);
  endtask

  initial begin : driver
    bit s;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) m_bank[b][i] = -1;
    m_cnt = 0; m_sw = 1'b0; m_d1 = 0; m_d2 = 0;

    // Reset held with random inputs.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 10'($urandom));
    note("reset");

    // Fill PING with 8s well past the tile size.
    for (int i = 0; i < 1200; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'd8, 10'($urandom_range(0, 1023)));
    note("fill_ping");

    // Swap: fill PONG with 7s while reading the last PING byte.
    for (int i = 0; i < 1200; i++)
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'd7, 10'd767);
    note("swap_read");

    // Swap back: read PONG top byte, then mix out-of-range and random reads.
    for (int i = 0; i < 600; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'd6, 10'd767);
    for (int i = 0; i < 600; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'd6,
           (i % 2 == 0) ? 10'd800 : 10'($urandom_range(0, 1023)));
    note("swap_back");

    // Mid-fill reset: restart a PING fill, reset after 300 writes, refill.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'($urandom), 10'($urandom));
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom), 10'($urandom_range(0, 767)));
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom), 10'($urandom));
    for (int i = 0; i < 800; i++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom), 10'($urandom_range(0, 767)));
    note("mid_reset");

    // Frozen: en=0 with writes offered and the switch toggling.
    for (int i = 0; i < 50; i++)
      step(1'b1, 1'b0, 1'($urandom), 1'b1, 8'($urandom), 10'($urandom));
    note("en_low");

    // Random traffic: occasional swaps, enable gaps, rare resets.
    s = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if (i % 1100 == 0) s = ~s;
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) != 0), s,
           ($urandom_range(0, 3) != 0), 8'($urandom),
           10'($urandom_range(0, 1023)));
    end
    note("random");

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
